// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked share of one UART TX between two byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a lock after TIMEOUT_CYCLES idle owner cycles.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  input  logic                  req1_last,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [1:0]            grant,
  output logic                  busy
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  slot, xfer0, xfer1, xfer, xlast, expire, done;

  // The buffer can take a byte when empty or draining this cycle.
  assign slot       = !tx_valid_q || tx_ready;
  assign req0_ready = (state_q == OWN0) && slot;
  assign req1_ready = (state_q == OWN1) && slot;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign xfer       = xfer0 || xfer1;
  assign xlast      = xfer1 ? req1_last : req0_last;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_valid;
  assign own_valid = (state_q == OWN1) ? req1_valid : req0_valid;
  assign expire    = (state_q != IDLE) && !own_valid && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d     = ((state_q == IDLE) || own_valid || expire) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expire = 1'b0;
`endif

  assign done = (xfer && xlast) || expire;

  always_comb begin
    state_d    = (state_q == IDLE) ?
                 ((req0_valid && req1_valid) ? (prio_q ? OWN1 : OWN0) :
                  req0_valid ? OWN0 : req1_valid ? OWN1 : IDLE) :
                 (done ? IDLE : state_q);
    prio_d     = done ? (state_q == OWN0) : prio_q;
    tx_valid_d = xfer || (tx_valid_q && !tx_ready);
    tx_data_d  = xfer ? (xfer1 ? req1_data : req0_data) : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant    = state_q;
  assign busy     = (state_q != IDLE) || tx_valid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus random traffic against a queue-based arbiter model.
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0, tx_data;
  logic          req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic          req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic          tx_valid, tx_ready = 1'b1, busy;
  logic [1:0]    grant;

  int total = 0;
  int bad = 0;

  int            owner;
  bit            prio;
  logic [DW-1:0] mq[$];
  int            idle_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    owner = 0;
    prio = 1'b0;
    mq.delete();
    idle_cnt = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit v0, input logic [DW-1:0] d0, input bit l0,
                      input bit v1, input logic [DW-1:0] d1, input bit l1, input bit tr);
    bit a0, a1, empty, ol, acc;
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    tx_ready = tr;
    @(negedge clk);
    empty = (mq.size() == 0);
    a0 = (owner == 1) && (empty || tr);
    a1 = (owner == 2) && (empty || tr);
    chk("grant", grant, owner);
    chk("tx_valid", tx_valid, !empty);
    if (!empty) chk("tx_data", tx_data, mq[0]);
    chk("req0_ready", req0_ready, a0);
    chk("req1_ready", req1_ready, a1);
    chk("busy", busy, (owner != 0) || !empty);
    if (!empty && tr) void'(mq.pop_front());
    if (a0 && v0) mq.push_back(d0);
    if (a1 && v1) mq.push_back(d1);
    if (owner == 0) begin
      owner = (v0 && v1) ? (prio ? 2 : 1) : v0 ? 1 : v1 ? 2 : 0;
    end else begin
      ol  = (owner == 1) ? l0 : l1;
      acc = (owner == 1) ? (a0 && v0) : (a1 && v1);
      if (acc && ol) begin
        prio = (owner == 1);
        owner = 0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (!((owner == 1) ? v0 : v1)) begin
        if (idle_cnt == TO - 1) begin
          prio = (owner == 1);
          owner = 0;
        end else idle_cnt++;
      end else idle_cnt = 0;
`endif
    end
    if (owner == 0) idle_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 8'h00, 0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_grant", grant, 2'b00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single source: "Hi"
    step(1, 8'h48, 0, 0, 8'h00, 0, 1);
    step(1, 8'h48, 0, 0, 8'h00, 0, 1);
    chk("ss_first", tx_data, 8'h48);
    step(1, 8'h69, 1, 0, 8'h00, 0, 1);
    chk("ss_second", tx_data, 8'h69);
    chk("ss_grant_idle", grant, 2'b00);
    idle(1);

    // Async reset while a byte is pending
    step(0, 8'h00, 0, 1, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1, 8'hA5, 0, 0);
    chk("pre_rst_valid", tx_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_grant", grant, 2'b00);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention from reset, then the lock held by requester 1
    step(1, 8'h10, 0, 1, 8'h20, 0, 1);
    chk("cont_first", grant, 2'b01);
    step(1, 8'h11, 1, 1, 8'h20, 0, 1);
    chk("cont_bubble", grant, 2'b00);
    step(1, 8'h12, 0, 1, 8'h20, 0, 1);
    chk("cont_second", grant, 2'b10);
    step(1, 8'h12, 0, 1, 8'h41, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 8'h12, 0, 0, 8'h00, 0, 1);
    chk("lock_grant", grant, 2'b10);
    chk("lock_ready0", req0_ready, 1'b0);
    step(1, 8'h12, 0, 1, 8'h42, 1, 1);
    step(1, 8'h55, 0, 0, 8'h00, 0, 1);
    chk("lock_handover", grant, 2'b01);

    // Backpressure on a pending 0x55
    step(1, 8'h55, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h56, 0, 0, 8'h00, 0, 0);
      chk("bp_hold", tx_data, 8'h55);
    end
    step(1, 8'h56, 0, 0, 8'h00, 0, 1);
    chk("bp_next_data", tx_data, 8'h56);
    chk("bp_next_valid", tx_valid, 1'b1);

    // Owner 0 silent while requester 1 waits
    for (int i = 0; i < TO; i++) step(0, 8'h00, 0, 1, 8'h77, 0, 1);
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_revoked", grant, 2'b00);
    step(0, 8'h00, 0, 1, 8'h77, 0, 1);
    chk("to_regrant", grant, 2'b10);
`else
    chk("no_to_lock", grant, 2'b01);
    step(1, 8'h57, 1, 1, 8'h77, 0, 1);
    chk("no_to_release", grant, 2'b00);
`endif

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
